// File: rtl/lane_reorder_pkg.sv
// Purpose : shared types for the lane reorder pipe (per-beat mode select).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package lane_reorder_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS     = 2'd0,
        MODE_BYTE_REV = 2'd1,
        MODE_BIT_REV  = 2'd2,
        MODE_HALF_REV = 2'd3
    } mode_e;

endpackage

// File: rtl/lane_reorder_comb.sv
// Purpose : combinational lane permutation of one data word by mode.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; no state, no handshake.
// Ports   : i_data/i_mode in, o_data reordered word out.
module lane_reorder_comb
    import lane_reorder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  mode_e             i_mode,
    output logic [DATA_W-1:0] o_data
);

    localparam int NBYTES = DATA_W / 8;
    localparam int NHALFS = DATA_W / 16;

    always_comb begin
        o_data = i_data;
        case (i_mode)
            MODE_PASS: begin
                o_data = i_data;
            end
            MODE_BYTE_REV: begin
                for (int k = 0; k < NBYTES; k++) begin
                    o_data[8*k +: 8] = i_data[8*(NBYTES-1-k) +: 8];
                end
            end
            MODE_BIT_REV: begin
                for (int i = 0; i < DATA_W; i++) begin
                    o_data[i] = i_data[DATA_W-1-i];
                end
            end
            MODE_HALF_REV: begin
                for (int k = 0; k < NHALFS; k++) begin
                    o_data[16*k +: 16] = i_data[16*(NHALFS-1-k) +: 16];
                end
            end
            default: begin
                o_data = i_data;
            end
        endcase
    end

endmodule

// File: rtl/lane_reorder_pipe.sv
// Purpose : registered lane-reorder stage with main + skid registers and beat counter.
// Latency : 1 cycle (beat accepted at edge N is on out_* after edge N).
// Backpr. : in_ready = !skid_valid from a flop; holds up to 2 beats when out_ready is low.
// Ports   : clk/rst_n; in_valid/in_ready/in_data/in_mode producer side;
//           out_valid/out_ready/out_data/out_mode consumer side; beat_count delivered beats.
module lane_reorder_pipe
    import lane_reorder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [MODE_W-1:0] out_mode,
    output logic [CNT_W-1:0]  beat_count
);

    logic [DATA_W-1:0] w_reord;
    logic              w_in_fire;
    logic              w_out_fire;

    logic              r_main_vld;
    logic [DATA_W-1:0] r_main_dat;
    logic [MODE_W-1:0] r_main_mode;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_dat;
    logic [MODE_W-1:0] r_skid_mode;
    logic [CNT_W-1:0]  r_beat_cnt;

    // Reorder happens once at acceptance; stored results are never recomputed.
    lane_reorder_comb #(
        .DATA_W (DATA_W)
    ) u_comb (
        .i_data (in_data),
        .i_mode (mode_e'(in_mode)),
        .o_data (w_reord)
    );

    assign w_in_fire  = in_valid && !r_skid_vld;
    assign w_out_fire = r_main_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld  <= 1'b0;
            r_main_dat  <= '0;
            r_main_mode <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_dat  <= '0;
            r_skid_mode <= '0;
        end else if (w_out_fire) begin
            // Main drains: refill from skid first to keep order; a new beat
            // cannot arrive alongside because in_ready is low while skid is full.
            if (r_skid_vld) begin
                r_main_dat  <= r_skid_dat;
                r_main_mode <= r_skid_mode;
                r_skid_vld  <= 1'b0;
            end else if (w_in_fire) begin
                r_main_dat  <= w_reord;
                r_main_mode <= in_mode;
            end else begin
                r_main_vld  <= 1'b0;
            end
        end else if (!r_main_vld) begin
            if (w_in_fire) begin
                r_main_vld  <= 1'b1;
                r_main_dat  <= w_reord;
                r_main_mode <= in_mode;
            end
        end else if (w_in_fire) begin
            // Main full and stalled: park the beat in skid.
            r_skid_vld  <= 1'b1;
            r_skid_dat  <= w_reord;
            r_skid_mode <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_out_fire) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = !r_skid_vld;
    assign out_valid  = r_main_vld;
    assign out_data   = r_main_dat;
    assign out_mode   = r_main_mode;
    assign beat_count = r_beat_cnt;

endmodule

// File: tb/tb_lane_reorder_pipe.sv
module tb_lane_reorder_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic [15:0] beat_count;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [63:0] w_in_data;
    logic [1:0]  w_in_mode;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_data;
    logic [1:0]  w_out_mode;
    logic [3:0]  w_beat_count;

    int n_checks = 0;
    int n_fail   = 0;

    lane_reorder_pipe #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mode   (out_mode),
        .beat_count (beat_count)
    );

    lane_reorder_pipe #(.DATA_W(64), .CNT_W(4)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w_in_valid),
        .in_ready   (w_in_ready),
        .in_data    (w_in_data),
        .in_mode    (w_in_mode),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_data   (w_out_data),
        .out_mode   (w_out_mode),
        .beat_count (w_beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: streaming-operator reorders for the 32-bit instance.
    function automatic logic [31:0] ref32(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'd1:    r = {<<8{d}};
            2'd2:    r = {<<{d}};
            2'd3:    r = {<<16{d}};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [33:0] sb[$];
    logic [33:0] exp_e;
    logic        hold_prev;
    logic [31:0] held_dat;
    logic [1:0]  held_mode;
    int          sent;
    int          delivered;
    int          cycles;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Four modes back to back on 32-bit, plus 64-bit BYTE_REV/HALF_REV/BIT_REV
        out_ready = 1'b1; w_out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h12345678; in_mode = 2'd0;
        w_in_valid = 1'b1; w_in_data = 64'h0102030405060708; w_in_mode = 2'd1;
        @(negedge clk);
        check("pass_dat", 64'(out_data), 64'h12345678);
        check("pass_mode", 64'(out_mode), 64'd0);
        check("w64_byterev", w_out_data, 64'h0807060504030201);
        in_mode = 2'd1; w_in_mode = 2'd3;
        @(negedge clk);
        check("byterev_dat", 64'(out_data), 64'h78563412);
        check("byterev_mode", 64'(out_mode), 64'd1);
        check("w64_halfrev", w_out_data, 64'h0708050603040102);
        in_mode = 2'd2; w_in_data = 64'h0000000000000001; w_in_mode = 2'd2;
        @(negedge clk);
        check("bitrev_dat", 64'(out_data), 64'h1E6A2C48);
        check("bitrev_mode", 64'(out_mode), 64'd2);
        check("w64_bitrev", w_out_data, 64'h8000000000000000);
        in_mode = 2'd3; w_in_valid = 1'b0;
        @(negedge clk);
        check("halfrev_dat", 64'(out_data), 64'h56781234);
        check("halfrev_mode", 64'(out_mode), 64'd3);
        check("halfrev_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("cnt_after4", 64'(beat_count), 64'd4);

        // Backpressure: two beats held, skid fills, in_ready falls
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11112222; in_mode = 2'd0;
        @(negedge clk);
        check("bp_a_dat", 64'(out_data), 64'h11112222);
        check("bp_rdy_after_a", 64'(in_ready), 64'd1);
        in_data = 32'hAABBCCDD; in_mode = 2'd1;
        @(negedge clk);
        check("bp_rdy_low", 64'(in_ready), 64'd0);
        check("bp_a_hold1", 64'(out_data), 64'h11112222);
        in_data = 32'h0F0F0000; in_mode = 2'd3;
        @(negedge clk);
        check("bp_rdy_low2", 64'(in_ready), 64'd0);
        check("bp_a_hold2", 64'(out_data), 64'h11112222);
        check("bp_a_mode_hold", 64'(out_mode), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_b_dat", 64'(out_data), 64'hDDCCBBAA);
        check("rel_b_mode", 64'(out_mode), 64'd1);
        check("rel_rdy_up", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("rel_c_dat", 64'(out_data), 64'h00000F0F);
        check("rel_c_mode", 64'(out_mode), 64'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_empty", 64'(out_valid), 64'd0);
        check("cnt_after7", 64'(beat_count), 64'd7);

        // Reset mid-stream with both registers full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hCAFEF00D; in_mode = 2'd0;
        repeat (2) @(negedge clk);
        check("pre_rst_full", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_count", 64'(beat_count), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h00000001; in_mode = 2'd2;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_dat", 64'(out_data), 64'h80000000);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 64'(out_valid), 64'd0);

        // 4-bit counter wrap on the 64-bit instance: 17 beats -> 1
        check("w64_cnt_rst", 64'(w_beat_count), 64'd0);
        for (int k = 0; k < 17; k++) begin
            w_in_valid = 1'b1; w_in_data = 64'(k); w_in_mode = 2'd0;
            @(negedge clk);
        end
        check("w64_cnt_16", 64'(w_beat_count), 64'd0);
        w_in_valid = 1'b0;
        @(negedge clk);
        check("w64_cnt_17", 64'(w_beat_count), 64'd1);
        check("w64_last_dat", w_out_data, 64'd16);

        // Random valid/ready over 1000 beats against a scoreboard
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sent = 0; delivered = 0; cycles = 0; hold_prev = 1'b0;
        while (!(sent >= 1000 && sb.size() == 0) && cycles < 8000) begin
            if (hold_prev) begin
                check("rnd_stable_dat", 64'(out_data), 64'(held_dat));
                check("rnd_stable_mode", 64'(out_mode), 64'(held_mode));
            end
            if (sent < 1000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_data = $urandom;
            in_mode = 2'($urandom_range(0, 3));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check("rnd_beat", {30'd0, out_mode, out_data}, 64'(exp_e));
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_mode, ref32(in_data, in_mode)});
                sent++;
            end
            hold_prev = out_valid && !out_ready;
            held_dat  = out_data;
            held_mode = out_mode;
            cycles++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rnd_sent", 64'(sent), 64'd1000);
        check("rnd_delivered", 64'(delivered), 64'd1000);
        check("rnd_sb_empty", 64'(sb.size()), 64'd0);
        check("rnd_beat_count", 64'(beat_count), 64'(16'(delivered)));
        check("rnd_out_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
